microprogram_sequencer: RTL and testbench

Microprogram sequencer and writable control store for the matrix-multiplication core. It holds the microcode, steps a micro-program counter (UPC) and presents one 49-bit microword per cycle on uOPs. ops_decoder consumes uOPs and expands it into DREAD/IREAD/DWRITE/BUSMEM/MEMBUSI and the remaining datapath controls. Branching uses the ALU zero flag, and memory waits use the memory-ready handshake.

---
 rtl/microprogram_sequencer.sv | 147 ++++++++++++++
 tb/tb_microprogram_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microprogram_sequencer.sv
// microprogram_sequencer: writable control store plus micro-program counter
// for the matrix-multiplication core. Presents one registered microword per
// cycle on uops for ops_decoder, with branching on the ALU zero flag and
// memory-ready waits.
// Optional feature: define USEQ_SUBROUTINE_EN to enable single-level
// CALL (COND 6) / RET (COND 7); otherwise both decode as SEQ.
module microprogram_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter int                UOP_W      = 49,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              z,
  input  logic              mem_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [UOP_W-1:0]  load_data,
  output logic [UOP_W-1:0]  uops,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    COND_SEQ  = 3'd0,
    COND_JMP  = 3'd1,
    COND_JZ   = 3'd2,
    COND_JNZ  = 3'd3,
    COND_WAIT = 3'd4,
    COND_END  = 3'd5,
    COND_CALL = 3'd6,
    COND_RET  = 3'd7
  } cond_e;

  state_e            state;
  logic [UOP_W-1:0]  mem [DEPTH];

  cond_e             cond;
  logic [ADDR_W-1:0] next_field;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              hold;
  logic              is_end;

`ifdef USEQ_SUBROUTINE_EN
  logic [ADDR_W-1:0] ret_reg;
  logic              is_call;
`endif

  assign cond       = cond_e'(uops[40:38]);
  assign next_field = ADDR_W'(uops[48:41]);
  assign seq_addr   = upc + ADDR_W'(1);

  // Control store writes, accepted only while idle.
  // NOTE: the control store has no reset; microcode must survive a reset,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Next-address selection from the COND field of the current microword.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_addr = seq_addr;
    hold      = 1'b0;
    is_end    = 1'b0;
`ifdef USEQ_SUBROUTINE_EN
    is_call   = 1'b0;
`endif
    case (cond)
      COND_SEQ:  next_addr = seq_addr;
      COND_JMP:  next_addr = next_field;
      COND_JZ:   next_addr = z ? next_field : seq_addr;
      COND_JNZ:  next_addr = z ? seq_addr : next_field;
      COND_WAIT: hold      = ~mem_ready;
      COND_END:  is_end    = 1'b1;
`ifdef USEQ_SUBROUTINE_EN
      COND_CALL: begin
        next_addr = next_field;
        is_call   = 1'b1;
      end
      COND_RET:  next_addr = ret_reg;
`endif
      default:   next_addr = seq_addr;
    endcase
  end

  // Sequencer FSM with registered microword, UPC and status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      uops    <= '0;
      upc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef USEQ_SUBROUTINE_EN
      ret_reg <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A load in the same cycle wins; START must be held or repeated.
          if (!load_en && start) begin
            upc   <= START_ADDR;
            uops  <= mem[START_ADDR];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (is_end) begin
            uops  <= '0;
            upc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (!hold) begin
            upc  <= next_addr;
            uops <= mem[next_addr];
`ifdef USEQ_SUBROUTINE_EN
            if (is_call) begin
              ret_reg <= seq_addr;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Directed testbench for microprogram_sequencer: reset, sequencing/END,
// branching and wrap, WAIT, load/start collisions, subroutine words.
module tb_microprogram_sequencer;

  localparam logic [2:0] C_SEQ  = 3'd0;
  localparam logic [2:0] C_JMP  = 3'd1;
  localparam logic [2:0] C_JZ   = 3'd2;
  localparam logic [2:0] C_WAIT = 3'd4;
  localparam logic [2:0] C_END  = 3'd5;
  localparam logic [2:0] C_CALL = 3'd6;
  localparam logic [2:0] C_RET  = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        z;
  logic        mem_ready;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [48:0] load_data;
  logic [48:0] uops;
  logic [7:0]  upc;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [48:0] w5;
  logic [48:0] w_wait;
  logic [48:0] w_end2;
  logic [48:0] w_col;

  microprogram_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .z         (z),
    .mem_ready (mem_ready),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .uops      (uops),
    .upc       (upc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] mk(input logic [7:0] nxt, input logic [2:0] c,
                                     input logic [37:0] ctl);
    return {nxt, c, ctl};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [48:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; z = 1'b0; mem_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    step(); step();
    check("rst_uops", uops, 0);
    check("rst_upc",  upc,  0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    step();

    // Sequential + END, with a load attempted during RUN
    load(8'd0, mk(8'h00, C_SEQ, 38'h00_0000_00A0));
    load(8'd1, mk(8'h00, C_SEQ, 38'h00_0000_00A1));
    load(8'd2, mk(8'h00, C_END, 38'h00_0000_00A2));
    pulse_start();
    check("seq_upc0",  upc, 8'd0);
    check("seq_uops0", uops, mk(8'h00, C_SEQ, 38'h00_0000_00A0));
    check("seq_busy",  busy, 1);
    load_addr = 8'd2; load_data = mk(8'h00, C_SEQ, 38'h3F_FFFF_FFFF); load_en = 1'b1;
    step();
    check("seq_upc1",  upc, 8'd1);
    step();
    load_en = 1'b0;
    check("seq_upc2",  upc, 8'd2);
    check("run_load_ignored", uops, mk(8'h00, C_END, 38'h00_0000_00A2));
    step();
    check("end_done", done, 1);
    check("end_uops", uops, 0);
    check("end_busy", busy, 0);
    check("end_upc",  upc, 0);
    step();
    check("done_pulse", done, 0);

    // JZ taken / not taken, and address wrap from 0xFF
    load(8'd0,   mk(8'h10, C_JZ,  38'h00_0000_00B0));
    load(8'h10,  mk(8'h00, C_END, 38'h00_0000_00B1));
    load(8'd1,   mk(8'h00, C_END, 38'h00_0000_00B2));
    z = 1'b1;
    pulse_start();
    step();
    check("jz_taken", upc, 8'h10);
    step();
    check("jz_taken_end", done, 1);
    z = 1'b0;
    pulse_start();
    step();
    check("jz_not_taken", upc, 8'h01);
    step();
    load(8'd0,   mk(8'hFF, C_JZ,  38'h00_0000_00B3));
    load(8'hFF,  mk(8'h00, C_SEQ, 38'h00_0000_00B4));
    z = 1'b1;
    pulse_start();
    step();
    check("jz_to_ff", upc, 8'hFF);
    z = 1'b0;
    step();
    check("wrap_upc", upc, 8'h00);
    step();
    check("wrap_then_seq", upc, 8'h01);
    step();
    check("wrap_end", done, 1);

    // WAIT holds UPC and uops until mem_ready is sampled high
    w_wait = mk(8'h00, C_WAIT, 38'h00_0000_00C3);
    load(8'd0, mk(8'h00, C_SEQ, 38'h00_0000_00C0));
    load(8'd1, mk(8'h00, C_SEQ, 38'h00_0000_00C1));
    load(8'd2, mk(8'h00, C_SEQ, 38'h00_0000_00C2));
    load(8'd3, w_wait);
    load(8'd4, mk(8'h00, C_END, 38'h00_0000_00C4));
    mem_ready = 1'b0;
    pulse_start();
    step(); step(); step();
    check("wait_reach", upc, 8'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wait_hold_upc%0d", i), upc, 8'd3);
      check($sformatf("wait_hold_uops%0d", i), uops, w_wait);
    end
    mem_ready = 1'b1;
    step();
    check("wait_release", upc, 8'd4);
    mem_ready = 1'b0;
    step();
    check("wait_end", done, 1);

    // LOAD_EN and START together: write happens, stays IDLE
    load(8'd0, mk(8'h40, C_JMP, 38'h00_0000_00D0));
    w_col = mk(8'h00, C_END, 38'h00_0000_00D1);
    load_addr = 8'h40; load_data = w_col; load_en = 1'b1; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    check("col_busy", busy, 0);
    step();
    check("col_still_idle", busy, 0);
    pulse_start();
    step();
    check("col_upc", upc, 8'h40);
    check("col_written", uops, w_col);
    step();

    // START held through END restarts after exactly one IDLE cycle
    w_end2 = mk(8'h00, C_END, 38'h00_0000_00E1);
    load(8'd0, mk(8'h00, C_SEQ, 38'h00_0000_00E0));
    load(8'd1, w_end2);
    start = 1'b1;
    step();
    check("hold_busy0", busy, 1);
    step();
    check("hold_upc1", upc, 8'd1);
    step();
    check("hold_idle_done", done, 1);
    check("hold_idle_busy", busy, 0);
    step();
    start = 1'b0;
    check("hold_restart_busy", busy, 1);
    check("hold_restart_upc", upc, 8'd0);
    step(); step();
    check("hold_end2", done, 1);

    // Subroutine words: CALL at 4 -> 0x20, RET back to 5
    load(8'd0, mk(8'h00, C_SEQ, 38'h00_0000_00F0));
    load(8'd1, mk(8'h00, C_SEQ, 38'h00_0000_00F1));
    load(8'd2, mk(8'h00, C_SEQ, 38'h00_0000_00F2));
    load(8'd3, mk(8'h00, C_SEQ, 38'h00_0000_00F3));
    load(8'd4, mk(8'h20, C_CALL, 38'h00_0000_00F4));
    load(8'h20, mk(8'h00, C_RET, 38'h00_0000_00F5));
    load(8'd5, mk(8'h00, C_SEQ, 38'h00_0000_00F6));
    load(8'd6, mk(8'h00, C_END, 38'h00_0000_00F7));
    load(8'h21, mk(8'h00, C_END, 38'h00_0000_00F8));
    pulse_start();
    step(); step(); step(); step();
    check("sub_upc4", upc, 8'd4);
    step();
`ifdef USEQ_SUBROUTINE_EN
    check("sub_call", upc, 8'h20);
    step();
    check("sub_ret", upc, 8'd5);
    step(); step(); step();
`else
    check("sub_call_as_seq", upc, 8'd5);
    step();
    check("sub_next_seq", upc, 8'd6);
    step(); step();
`endif
    check("sub_done_idle", busy, 0);

    // Asynchronous reset mid-RUN at UPC=5, control store survives
    w5 = mk(8'h00, C_SEQ, 38'h15_5555_5555);
    for (int a = 0; a < 5; a++) load(8'(a), mk(8'h00, C_SEQ, 38'(a)));
    load(8'd5, w5);
    load(8'd6, mk(8'h00, C_END, 38'h00_0000_0006));
    pulse_start();
    step(); step(); step(); step(); step();
    check("rst_pre_upc", upc, 8'd5);
    #2 reset = 1'b0;
    #1;
    check("async_rst_uops", uops, 0);
    check("async_rst_upc",  upc, 0);
    check("async_rst_busy", busy, 0);
    #1 reset = 1'b1;
    step();
    pulse_start();
    step(); step(); step(); step(); step();
    check("restart_upc5", upc, 8'd5);
    check("mem_kept_w5", uops, w5);
    step(); step();
    check("restart_end", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
